// File: rtl/seven_seg_ctrl.sv
// seven_seg_ctrl: converts an unsigned value into per-digit nibbles for a
// six-digit seven-segment display. Hex mode commits the value's nibbles
// directly. Decimal mode runs a serial double-dabble conversion, one bit
// per clock. Optional leading-zero blanking is supported, and decimal
// values above 999999 are flagged as an overflow.
module seven_seg_ctrl #(
    parameter int DIGITS  = 6,
    parameter int VALUE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    in_value,
    input  logic                  in_hex,
    input  logic                  in_lz,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf,
    output logic                  done
);

    localparam int NIB_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [VALUE_W-1:0]   value_sh;     // latched value; shifted out MSB first in CONV
    logic                 hex_q;
    logic                 lz_q;
    logic                 big_q;        // decimal value does not fit in six digits
    logic [NIB_W-1:0]     bcd;          // conversion scratch, never visible on ports
    logic [CNT_W-1:0]     iter;

    logic                 accept;
    logic                 last_iter;
    logic [NIB_W-1:0]     bcd_adj;
    logic [VALUE_W+NIB_W-1:0] value_ext;
    logic [NIB_W-1:0]     hex_val;
    logic [NIB_W-1:0]     commit_val;
    logic [DIGITS-1:0]    commit_blank;
    logic                 zero_above;

    assign accept    = in_valid && in_ready;
    assign last_iter = (iter == CNT_W'(VALUE_W - 1));

    // Zero-fill the value up to the full nibble width for hex mode.
    assign value_ext = {{NIB_W{1'b0}}, value_sh};
    assign hex_val   = value_ext[NIB_W-1:0];

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and ready handshake.
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_next = in_hex ? COMMIT : CONV;
            end
            CONV:    if (last_iter) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Select the value to commit and derive leading-zero blanking from it.
    always_comb begin
        if (hex_q)      commit_val = hex_val;
        else if (big_q) commit_val = {DIGITS{4'h9}};
        else            commit_val = bcd;

        commit_blank = '0;
        zero_above   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (commit_val[4*i +: 4] != 4'd0) zero_above = 1'b0;
            commit_blank[i] = lz_q && zero_above;
        end
    end

    // Datapath: latch the request, run the conversion, and commit outputs in one step.
    // NOTE: all datapath registers are reset. The outputs must read zero
    // during reset, and no stale conversion state may survive an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_sh <= '0;
            hex_q    <= 1'b0;
            lz_q     <= 1'b0;
            big_q    <= 1'b0;
            bcd      <= '0;
            iter     <= '0;
            digits   <= '0;
            blank    <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        value_sh <= in_value;
                        hex_q    <= in_hex;
                        lz_q     <= in_lz;
                        big_q    <= !in_hex && (32'(in_value) > 32'd999999);
                        bcd      <= '0;
                        iter     <= '0;
                    end
                end
                CONV: begin
                    {bcd, value_sh} <= {bcd_adj, value_sh} << 1;
                    iter            <= iter + CNT_W'(1);
                end
                COMMIT: begin
                    digits <= commit_val;
                    blank  <= commit_blank;
                    ovf    <= big_q;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Self-checking bench for seven_seg_ctrl. It applies a table of directed
// vectors, then randomized requests checked against an arithmetic model,
// then back-pressure and reset-abort sequences.
module tb_seven_seg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] in_value;
    logic        in_hex;
    logic        in_lz;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        ovf;
    logic        done;

    int total = 0;
    int bad   = 0;

    seven_seg_ctrl #(.DIGITS(6), .VALUE_W(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_hex   (in_hex),
        .in_lz    (in_lz),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .digits   (digits),
        .blank    (blank),
        .ovf      (ovf),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] v;
        logic        h;
        logic        l;
        logic [23:0] d;
        logic [5:0]  b;
        logic        o;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by repeated division, hex by nibbles.
    function automatic void model(input logic [19:0] v, input logic h, input logic l,
                                  output logic [23:0] d, output logic [5:0] b,
                                  output logic o);
        int unsigned tmp;
        o = 1'b0;
        d = '0;
        if (h) begin
            d = {4'h0, v};
        end else if (v > 20'd999999) begin
            d = 24'h999999;
            o = 1'b1;
        end else begin
            tmp = v;
            for (int i = 0; i < 6; i++) begin
                d[4*i +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
        end
        b = '0;
        if (l) begin
            for (int i = 5; i > 0; i--) begin
                if (d[4*i +: 4] != 4'd0) break;
                b[i] = 1'b1;
            end
        end
    endfunction

    // Issue one request, wait for its commit, and check latency, outputs, and the pulse width.
    task automatic run_req(input logic [19:0] v, input logic h, input logic l,
                           input logic [23:0] ed, input logic [5:0] eb, input logic eo,
                           input string tag);
        int n;
        int lat;
        @(negedge clk);
        in_value = v;
        in_hex   = h;
        in_lz    = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), h ? 64'd1 : 64'd21);
        check({tag, " digits"}, 64'(digits), 64'(ed));
        check({tag, " blank"}, 64'(blank), 64'(eb));
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
        check({tag, " done width"}, 64'(done), 64'd0);
        check({tag, " hold"}, 64'(digits), 64'(ed));
    endtask

    initial begin
        logic [19:0] rv;
        logic        rh, rl, eo, seen_ready, seen_done;
        logic [23:0] ed;
        logic [5:0]  eb;
        int          lat;

        vecs[0]  = '{20'd123456,  1'b0, 1'b0, 24'h123456, 6'b000000, 1'b0};
        vecs[1]  = '{20'h00A3F,   1'b1, 1'b1, 24'h000A3F, 6'b111000, 1'b0};
        vecs[2]  = '{20'd1000000, 1'b0, 1'b0, 24'h999999, 6'b000000, 1'b1};
        vecs[3]  = '{20'd0,       1'b0, 1'b1, 24'h000000, 6'b111110, 1'b0};
        vecs[4]  = '{20'd999999,  1'b0, 1'b1, 24'h999999, 6'b000000, 1'b0};
        vecs[5]  = '{20'hFFFFF,   1'b1, 1'b1, 24'h0FFFFF, 6'b100000, 1'b0};
        vecs[6]  = '{20'd1048575, 1'b0, 1'b1, 24'h999999, 6'b000000, 1'b1};
        vecs[7]  = '{20'd7,       1'b0, 1'b1, 24'h000007, 6'b111110, 1'b0};
        vecs[8]  = '{20'd100,     1'b1, 1'b1, 24'h000064, 6'b111100, 1'b0};
        vecs[9]  = '{20'd100200,  1'b0, 1'b1, 24'h100200, 6'b000000, 1'b0};
        vecs[10] = '{20'd0,       1'b1, 1'b0, 24'h000000, 6'b000000, 1'b0};
        vecs[11] = '{20'd5,       1'b0, 1'b0, 24'h000005, 6'b000000, 1'b0};
        vecs[12] = '{20'd90,      1'b0, 1'b1, 24'h000090, 6'b111100, 1'b0};

        rst = 1'b1; in_value = '0; in_hex = 1'b0; in_lz = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset digits", 64'(digits), 64'd0);
        check("reset blank", 64'(blank), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1 check("ready after reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++)
            run_req(vecs[i].v, vecs[i].h, vecs[i].l, vecs[i].d, vecs[i].b, vecs[i].o,
                    $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv = 20'($urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 19));
            if (i % 8 == 0) rv = 20'($urandom_range(999990, 1000010));
            rh = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            model(rv, rh, rl, ed, eb, eo);
            run_req(rv, rh, rl, ed, eb, eo, $sformatf("rand%0d", i));
        end

        // Back-pressure: in_valid stays high through a conversion.
        @(negedge clk);
        in_value = 20'd654321; in_hex = 1'b0; in_lz = 1'b0; in_valid = 1'b1;
        check("bp first ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_value = 20'd111;
        seen_ready = 1'b0;
        for (int k = 1; k < 21; k++) begin
            @(posedge clk);
            #1;
            if (in_ready || done) seen_ready = 1'b1;
        end
        check("bp ready low in conv", 64'(seen_ready), 64'd0);
        @(posedge clk);
        #1;
        check("bp first done", 64'(done), 64'd1);
        check("bp first digits", 64'(digits), 64'h654321);
        check("bp ready with done", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp second accepted", 64'(in_ready), 64'd0);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp second latency", 64'(lat), 64'd21);
        check("bp second digits", 64'(digits), 64'h000111);

        // Reset during conversion of 999999 aborts with no pulse.
        @(negedge clk);
        in_value = 20'd999999; in_hex = 1'b0; in_lz = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort digits", 64'(digits), 64'd0);
        check("abort blank", 64'(blank), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        check("abort ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort ready after reset", 64'(in_ready), 64'd1);
        seen_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort no done", 64'(seen_done), 64'd0);
        check("abort digits held", 64'(digits), 64'd0);
        run_req(20'd42, 1'b0, 1'b0, 24'h000042, 6'b000000, 1'b0, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_ctrl.md
SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase names them: clk, rst.
REQ-002 Parameter: DIGITS, default 6, number of display digits; only 6 is required to be supported.
REQ-003 Parameter: VALUE_W, default 20, input value width in bits.
REQ-004 Port clk, input, 1, rising-edge system clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port in_value, input, VALUE_W, unsigned value to display.
REQ-007 Port in_hex, input, 1, display mode: 1 = hexadecimal, 0 = decimal.
REQ-008 Port in_lz, input, 1, leading-zero blanking enable.
REQ-009 Port in_valid, input, 1, request is valid this cycle.
REQ-010 Port in_ready, output, 1, block can accept a request this cycle.
REQ-011 Port digits, output, 4*DIGITS, one nibble per digit, digit 0 in bits [3:0], feeds the per-digit decoders.
REQ-012 Port blank, output, DIGITS, 1 = digit i is to be driven dark.
REQ-013 Port ovf, output, 1, last committed decimal value exceeded 999999.
REQ-014 Port done, output, 1, one-cycle pulse marking a new commit on digits/blank/ovf.

Function
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_value, in_hex and in_lz SHALL be latched at that edge.
REQ-016 The FSM SHALL have the states IDLE, CONV and COMMIT; in_ready SHALL be 1 only in IDLE and never while rst is 1.
REQ-017 IDLE SHALL go to COMMIT on acceptance with in_hex=1, and to CONV on acceptance with in_hex=0.
REQ-018 Hex mode: nibble i SHALL equal value[4i+3:4i], with bits above VALUE_W zero-filled; ovf SHALL be 0.
REQ-019 Decimal mode: CONV SHALL run exactly VALUE_W shift-add-3 (double-dabble) iterations, one per clock, then go to COMMIT.
REQ-020 In each iteration, every BCD nibble >= 5 SHALL have 3 added before the one-bit left shift, and the shift SHALL take the value's MSB first.
REQ-021 If the latched decimal value is > 999999, the commit SHALL load every nibble with 9 and set ovf=1; otherwise ovf SHALL be 0.
REQ-022 COMMIT SHALL update digits, blank and ovf together, assert done for exactly that one cycle, and return to IDLE.
REQ-023 Latency, counted from the accept edge E0: hex outputs and done SHALL appear after edge E1; decimal after edge E(VALUE_W+1), which is E21 by default.
REQ-024 digits, blank and ovf SHALL hold their values between commits; intermediate conversion state SHALL never appear on the outputs.
REQ-025 With in_lz=1, blank[i] SHALL be 1 for every digit i above the highest nonzero digit; blank[0] SHALL always be 0, so a value of 0 shows a single "0".
REQ-026 With in_lz=0, blank SHALL be all zeros.
REQ-027 in_valid asserted while in_ready=0 SHALL be ignored and not queued; the requester must hold in_valid until accepted.
REQ-028 A new request SHALL be acceptable in the cycle immediately after done, with no dead cycle beyond that IDLE cycle.

Reset
REQ-029 While rst=1 at an edge, the block SHALL enter IDLE and drive digits=0, blank=0, ovf=0, done=0 and in_ready=0.
REQ-030 Reset asserted during CONV or COMMIT SHALL abort the operation with no done pulse and no partial commit.
REQ-031 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-032 Decimal: in_value=123456, in_hex=0, in_lz=0 -> after E21, digits=24'h123456, blank=0, ovf=0, done high for 1 cycle.
REQ-033 Hex with blanking: in_value=20'h00A3F, in_hex=1, in_lz=1 -> after E1, digits=24'h000A3F, blank=6'b111000.
REQ-034 Overflow: in_value=1000000, decimal -> digits=24'h999999, ovf=1; a following request of 0 with in_lz=1 -> digits=0, blank=6'b111110, ovf=0.
REQ-035 Back-pressure: in_valid held high through a conversion -> in_ready=0 during CONV; the second request is accepted in the cycle after done; both values are committed in order.
REQ-036 Reset mid-operation: rst asserted at iteration 10 of 999999 -> no done pulse, outputs equal 0; the next request 42 gives digits=24'h000042.
